// File: rtl/cmac_chain_ctrl.sv
// CMAC (RFC 4493) chaining controller wrapped around a combinational AES-128 encrypt core.
// Optional build macro CMAC_SUBKEY_CACHE_EN: adds key_chg and reuses K1/K2 across starts.
module cmac_chain_ctrl #(
    parameter int AES_WAIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    input  logic         blk_last,
    input  logic [4:0]   blk_bytes,
    output logic [127:0] aes_in,
    input  logic [127:0] aes_out,
    output logic         busy,
    output logic         mac_valid,
    output logic [127:0] mac
`ifdef CMAC_SUBKEY_CACHE_EN
    ,
    input  logic         key_chg
`endif
);

    typedef enum logic [2:0] {IDLE, GEN_L, WAIT_BLK, ENC, DONE} state_t;

    localparam int            CW       = $clog2(AES_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(AES_WAIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  aes_in_q, aes_in_d;
    logic [127:0]  x_q, x_d;
    logic [127:0]  k1_q, k1_d;
    logic [127:0]  k2_q, k2_d;
    logic [127:0]  mac_q, mac_d;
    logic          mac_valid_q, mac_valid_d;
    logic          last_q, last_d;
`ifdef CMAC_SUBKEY_CACHE_EN
    logic          sk_ok_q, sk_ok_d;
`endif

    // Multiply by x in GF(2^128) with the CMAC reduction polynomial.
    function automatic logic [127:0] dbl(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic logic [127:0] last_block(input logic [127:0] data,
                                                input logic [4:0]   nbytes,
                                                input logic [127:0] k1,
                                                input logic [127:0] k2);
        logic [6:0]   nbits;
        logic [127:0] keep;
        if (nbytes >= 5'd16) return data ^ k1;
        nbits = {nbytes[3:0], 3'b000};
        keep  = ~({128{1'b1}} >> nbits);
        return ((data & keep) | (128'h1 << (7'd127 - nbits))) ^ k2;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        aes_in_d    = aes_in_q;
        x_d         = x_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        mac_d       = mac_q;
        mac_valid_d = mac_valid_q;
        last_d      = last_q;
`ifdef CMAC_SUBKEY_CACHE_EN
        sk_ok_d     = sk_ok_q;
`endif
        // start outranks everything, including a handshake in the same cycle
        if (start) begin
            x_d         = '0;
            cnt_d       = '0;
            mac_valid_d = 1'b0;
`ifdef CMAC_SUBKEY_CACHE_EN
            if (sk_ok_q && !key_chg) begin
                state_d = WAIT_BLK;
            end else begin
                state_d  = GEN_L;
                aes_in_d = '0;
            end
`else
            state_d  = GEN_L;
            aes_in_d = '0;
`endif
        end else begin
            case (state_q)
                GEN_L: begin
                    if (cnt_q == CNT_LAST) begin
                        k1_d    = dbl(aes_out);
                        k2_d    = dbl(dbl(aes_out));
                        cnt_d   = '0;
                        state_d = WAIT_BLK;
`ifdef CMAC_SUBKEY_CACHE_EN
                        sk_ok_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_BLK: begin
                    if (blk_valid) begin
                        aes_in_d = x_q ^ (blk_last ? last_block(blk_data, blk_bytes, k1_q, k2_q)
                                                   : blk_data);
                        last_d   = blk_last;
                        cnt_d    = '0;
                        state_d  = ENC;
                    end
                end
                ENC: begin
                    if (cnt_q == CNT_LAST) begin
                        x_d   = aes_out;
                        cnt_d = '0;
                        if (last_q) begin
                            mac_d       = aes_out;
                            mac_valid_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            state_d = WAIT_BLK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
`ifdef CMAC_SUBKEY_CACHE_EN
        if (key_chg) sk_ok_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            aes_in_q    <= '0;
            x_q         <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            mac_q       <= '0;
            mac_valid_q <= 1'b0;
            last_q      <= 1'b0;
`ifdef CMAC_SUBKEY_CACHE_EN
            sk_ok_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aes_in_q    <= aes_in_d;
            x_q         <= x_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            mac_q       <= mac_d;
            mac_valid_q <= mac_valid_d;
            last_q      <= last_d;
`ifdef CMAC_SUBKEY_CACHE_EN
            sk_ok_q     <= sk_ok_d;
`endif
        end
    end

    assign blk_ready = (state_q == WAIT_BLK);
    assign busy      = (state_q == GEN_L) || (state_q == WAIT_BLK) || (state_q == ENC);
    assign aes_in    = aes_in_q;
    assign mac       = mac_q;
    assign mac_valid = mac_valid_q;

endmodule

// File: tb/tb_cmac_chain_ctrl.sv
// Bench for cmac_chain_ctrl: behavioural AES-128 core, RFC 4493 vectors, random messages vs a byte-level CMAC model.
module tb_cmac_chain_ctrl;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [511:0] MSG = 512'h6bc1bee22e409f96e93d7e117393172aae2d8a571e03ac9c9eb76fac45af8e5130c81c46a35ce411e5fbc1191a0a52eff69f2445df4f9b17ad2b417be66c3710;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         blk_last;
    logic [4:0]   blk_bytes;
    logic [127:0] aes_in;
    logic [127:0] aes_out;
    logic         busy;
    logic         mac_valid;
    logic [127:0] mac;
`ifdef CMAC_SUBKEY_CACHE_EN
    logic         key_chg;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    cmac_chain_ctrl #(.AES_WAIT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .blk_bytes (blk_bytes),
        .aes_in    (aes_in),
        .aes_out   (aes_out),
        .busy      (busy),
        .mac_valid (mac_valid),
        .mac       (mac)
`ifdef CMAC_SUBKEY_CACHE_EN
        ,
        .key_chg   (key_chg)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv, s, r;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        r = inv;
        s = inv;
        for (int k = 0; k < 4; k++) begin
            s = {s[6:0], s[7]};
            r = r ^ s;
        end
        return r ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) s[j+4*c] = t[j + 4*((c+j)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    always_comb aes_out = aes128(aes_in, KEY);

    // ---------------- CMAC reference (byte-level) ----------------
    function automatic logic [127:0] gf_double(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic logic [127:0] cmac_ref(input logic [511:0] data, input int len);
        logic [127:0] l, k1, k2, x, blk;
        logic [7:0]   byt;
        int           nb, idx;
        bit           full;
        l    = aes128(128'h0, KEY);
        k1   = gf_double(l);
        k2   = gf_double(k1);
        nb   = (len + 15) / 16;
        full = (nb > 0) && (len % 16 == 0);
        if (nb == 0) nb = 1;
        x = 128'h0;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 16; j++) begin
                idx = 16*b + j;
                if (idx < len)       byt = data[511-8*idx -: 8];
                else if (idx == len) byt = 8'h80;
                else                 byt = 8'h00;
                blk[127-8*j -: 8] = byt;
            end
            if (b == nb - 1) blk = blk ^ (full ? k1 : k2);
            x = aes128(x ^ blk, KEY);
        end
        return x;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired, got no event expected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_hs();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (blk_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        if (!ok) fail_now("handshake_timeout");
    endtask

    task automatic wait_mac();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mac_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("mac_timeout");
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic feed(input logic [511:0] data, input int len, input int gapmax);
        int nb;
        int g;
        nb = (len == 0) ? 1 : (len + 15) / 16;
        for (int b = 0; b < nb; b++) begin
            g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            repeat (g) tick();
            blk_valid = 1'b1;
            blk_data  = data[511-128*b -: 128];
            blk_last  = (b == nb - 1);
            blk_bytes = blk_last ? 5'(len - 16*b) : 5'($urandom_range(31, 0));
            wait_hs();
            blk_valid = 1'b0;
            blk_data  = rnd128();
            blk_last  = $urandom_range(1, 0) == 1;
        end
    endtask

    task automatic run_msg(input logic [511:0] data, input int len, input int gapmax);
        start_pulse();
        feed(data, len, gapmax);
        wait_mac();
    endtask

    typedef struct {
        int           len;
        int           gap;
        logic [127:0] exp_mac;
    } vec_t;

    vec_t         vt [4];
    logic [511:0] rdata;
    int           rlen;

    initial begin
        vt[0] = '{len: 0,  gap: 0, exp_mac: 128'hbb1d6929e95937287fa37d129b756746};
        vt[1] = '{len: 16, gap: 0, exp_mac: 128'h070a16b46b4d4144f79bdd9dd04a287c};
        vt[2] = '{len: 40, gap: 3, exp_mac: 128'hdfa66747de9ae63030ca32611497c827};
        vt[3] = '{len: 64, gap: 2, exp_mac: 128'h51f0bebf7e3b9d92fc49741779363cfe};

        rst_n     = 1'b0;
        start     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_last  = 1'b0;
        blk_bytes = '0;
`ifdef CMAC_SUBKEY_CACHE_EN
        key_chg   = 1'b0;
`endif
        tick();
        tick();
        chk("reset_outputs", {blk_ready, busy, mac_valid}, 3'b000);
        chk("reset_aes_in", aes_in, 128'h0);
        chk("reset_mac", mac, 128'h0);
        rst_n = 1'b1;
        tick();

        // subkey generation and empty message, cycle by cycle
        start_pulse();
        chk("genl_state", {busy, blk_ready}, 2'b10);
        chk("genl_aes_in", aes_in, 128'h0);
        tick();
        chk("subkeys_ready", blk_ready, 1'b1);
        chk("k1", dut.k1_q, 128'hfbeed618357133667c85e08f7236a8de);
        chk("k2", dut.k2_q, 128'hf7ddac306ae266ccf90bc11ee46d513b);
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        blk_bytes = 5'd0;
        blk_data  = rnd128();
        tick();
        blk_valid = 1'b0;
        chk("enc_state", {busy, blk_ready, mac_valid}, 3'b100);
        tick();
        chk("empty_done", {busy, mac_valid}, 2'b01);
        chk("empty_mac", mac, 128'hbb1d6929e95937287fa37d129b756746);
        blk_valid = 1'b1;
        repeat (3) tick();
        blk_valid = 1'b0;
        chk("mac_held", {mac_valid, blk_ready}, 2'b10);
        chk("mac_held_val", mac, 128'hbb1d6929e95937287fa37d129b756746);

        // RFC 4493 vectors
        for (int i = 0; i < 4; i++) begin
            run_msg(MSG, vt[i].len, vt[i].gap);
            chk($sformatf("rfc_len%0d", vt[i].len), mac, vt[i].exp_mac);
            chk($sformatf("rfc_len%0d_flags", vt[i].len), {busy, mac_valid}, 2'b01);
        end

        // abort during ENC of block 2, then a one-block message
        do_reset();
        start_pulse();
        blk_valid = 1'b1; blk_data = MSG[511:384]; blk_last = 1'b0; blk_bytes = 5'd16;
        wait_hs();
        blk_data = MSG[383:256];
        wait_hs();
        blk_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_state", {busy, mac_valid}, 2'b10);
        feed(MSG, 16, 0);
        wait_mac();
        chk("abort_replay_mac", mac, 128'h070a16b46b4d4144f79bdd9dd04a287c);

        // start wins over a simultaneous handshake; the offered block is dropped
        do_reset();
        start_pulse();
        tick();
        blk_valid = 1'b1; blk_data = rnd128(); blk_last = 1'b1; blk_bytes = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        blk_valid = 1'b0;
        feed(MSG, 16, 0);
        wait_mac();
        chk("start_priority_mac", mac, 128'h070a16b46b4d4144f79bdd9dd04a287c);

        // reset mid-GEN_L and mid-ENC
        start_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_genl_flags", {blk_ready, busy, mac_valid}, 3'b000);
        chk("rst_genl_mac", mac, 128'h0);
        chk("rst_genl_aes_in", aes_in, 128'h0);
        start_pulse();
        blk_valid = 1'b1; blk_data = MSG[511:384]; blk_last = 1'b0;
        wait_hs();
        blk_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_enc_flags", {blk_ready, busy, mac_valid}, 3'b000);
        chk("rst_enc_aes_in", aes_in, 128'h0);

`ifdef CMAC_SUBKEY_CACHE_EN
        run_msg(MSG, 16, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cache_fast_ready", blk_ready, 1'b1);
        chk("cache_no_zero_aes_in", aes_in == 128'h0, 1'b0);
        feed(MSG, 16, 0);
        wait_mac();
        chk("cache_mac", mac, 128'h070a16b46b4d4144f79bdd9dd04a287c);
        start = 1'b1; key_chg = 1'b1;
        tick();
        start = 1'b0; key_chg = 1'b0;
        chk("keychg_genl", {busy, blk_ready}, 2'b10);
        tick();
        chk("keychg_ready", blk_ready, 1'b1);
`endif

        // random messages with random garbage past the end and random gaps
        for (int n = 0; n < 40; n++) begin
            rdata = {rnd128(), rnd128(), rnd128(), rnd128()};
            rlen  = $urandom_range(64, 0);
            run_msg(rdata, rlen, $urandom_range(3, 0));
            chk($sformatf("rand%0d_len%0d", n, rlen), mac, cmac_ref(rdata, rlen));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
